writeback_regfile: RTL and testbench
====================================

Name: writeback_regfile

Overview:
Final pipeline stage, directly downstream of the memory access stage. Consumes its stage_status_t output, commits results into the architectural integer register file, and serves the decode stage's two read ports with same-cycle write-through bypass. Also maintains the cycle and retired-instruction counters, and emits a registered commit record for trace and debug.

Parameters:
XLEN, 32, data width of registers and read ports
REG_COUNT, 32, number of architectural registers; index 0 is hardwired zero
REG_ADDR_W, 5, register index width; must equal clog2(REG_COUNT)
CNT_W, 64, width of the cycle and instret counters

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  synchronous reset, active-low
stage_in  in  stage_status_t  memory access stage output (valid, pc, instruction, data.address = rd, data.data = result, data.valid)
stage_out  out  stage_status_t  the stage_in record registered one cycle; commit trace record
rs1_address  in  REG_ADDR_W  decode read port 1 index
rs1_data  out  XLEN  decode read port 1 data
rs2_address  in  REG_ADDR_W  decode read port 2 index
rs2_data  out  XLEN  decode read port 2 data
fwd_address  out  REG_ADDR_W  rd currently being written; 0 when no write
fwd_data  out  XLEN  value currently being written
cycle_count  out  CNT_W  cycles since reset release
instret_count  out  CNT_W  retired instructions since reset release

Behaviour:
- Reset is synchronous and active-low: on a rising clk edge with rst_n = 0, registers x1..x31, both counters, and all stage_out fields clear to 0. stage_in is ignored that cycle; reset wins over any simultaneous write.
- Commit condition: we = stage_in.valid & stage_in.data.valid & (stage_in.data.address != 0).
- Upstream drives data.address = 0 for instructions that do not write rd (stores, branches, bubbles). Index 0 is therefore never written.
- Write timing: when we = 1, regs[data.address] <= data.data at the rising edge. The new value is architecturally visible from the next cycle.
- Read ports are combinational:
  - rsN_data = 0 if rsN_address == 0.
  - Otherwise, if we = 1 and rsN_address == data.address, rsN_data = stage_in.data.data (write-through bypass, same cycle).
  - Otherwise, rsN_data = regs[rsN_address].
  - Both ports may address the same register, or the written register, simultaneously; the bypass applies to each port independently.
- Forwarding outputs: fwd_address = we ? data.address : 0; fwd_data = we ? data.data : 0. Both are combinational.
- Counters:
  - cycle_count increments by 1 every non-reset cycle.
  - instret_count increments by 1 on every cycle with stage_in.valid = 1, whether or not rd is written.
  - Both wrap modulo 2^CNT_W with no saturation or flag.
- Commit record: stage_out is stage_in registered with one-cycle latency.
  - stage_out.valid = registered stage_in.valid.
  - stage_out.data.valid = registered we.
  - stage_out.ready = 1 constantly; this stage never stalls.
- No backpressure: stage_in.ready is not consumed; one record is accepted per cycle.
- Reset released mid-pipeline: the first post-reset cycle commits stage_in normally if it is valid.
- An address outside the REG_COUNT range cannot occur, since REG_ADDR_W = clog2(REG_COUNT).

Decomposition:
- Shared cpu types package holds stage_status_t, instruction_t, and the reg_rd_src and memory_mask enums; no new typedefs are required.
- Add REG_ADDR_W and XLEN constants to the package if they are not already present.
- One natural sub-module: register_file (flop array, one write port, two async read ports with bypass and x0 handling). The top level adds the counters, the commit-condition logic, and the stage_out register.

Test Plan:
- Reset: hold rst_n = 0 for 2 cycles with valid stage_in writing x5 = 0xDEADBEEF -> all rsN_data read 0, both counters 0, stage_out.valid = 0; x5 still reads 0 after release.
- Basic write: valid, data.valid = 1, rd = 5, data = 0x12345678 -> same cycle rs1_address = 5 gives 0x12345678 (bypass); next cycle, with stage_in idle, it still reads 0x12345678 and instret_count = 1.
- x0 protection: write rd = 0, data = 0xFFFFFFFF -> rs1/rs2 at index 0 read 0 in both the same and the next cycle; fwd_address = 0; instret_count still increments.
- Non-writing retire: valid = 1, data.valid = 0, rd = 7, data = 0xAA -> x7 unchanged (0); instret_count increments; stage_out.data.valid = 0 next cycle.
- Back-to-back and dual read: write x3 = 1, then x3 = 2 on consecutive cycles, with rs1 = rs2 = 3 throughout -> both ports read 1, then 2, then 2. cycle_count advances 1 per cycle; stage_out.data.data trails stage_in by exactly 1 cycle.
- Counter wrap (CNT_W = 8 build): 256 valid cycles -> instret_count returns to 0, no glitch on other outputs.

Source files
------------

// File: rtl/writeback_regfile_pkg.sv
// Shared CPU pipeline types: stage status record, instruction word and decode enums.
// Widths here fix the layout of every pipeline record.
package writeback_regfile_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_COUNT  = 32;
  localparam int unsigned REG_ADDR_W = $clog2(REG_COUNT);

  typedef logic [31:0] instruction_t;

  typedef enum logic [1:0] {
    RdSrcAlu,
    RdSrcMem,
    RdSrcPcPlus4,
    RdSrcImm
  } reg_rd_src_t;

  typedef enum logic [1:0] {
    MaskByte,
    MaskHalf,
    MaskWord
  } memory_mask_t;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] address;
    logic [XLEN-1:0]       data;
    logic                  valid;
  } reg_write_t;

  typedef struct packed {
    logic            valid;
    logic            ready;
    logic [XLEN-1:0] pc;
    instruction_t    instruction;
    reg_write_t      data;
  } stage_status_t;

endpackage

// File: rtl/writeback_regfile_register_file.sv
// Integer register file: one synchronous write port, two combinational read ports
// with same-cycle write-through bypass; entry 0 always reads as zero.
module writeback_regfile_register_file #(
  parameter int unsigned DataW   = 32,
  parameter int unsigned NumRegs = 32,
  parameter int unsigned AddrW   = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [DataW-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr1_i,
  output logic [DataW-1:0] rdata1_o,
  input  logic [AddrW-1:0] raddr2_i,
  output logic [DataW-1:0] rdata2_o
);

  logic [DataW-1:0] regs_q [NumRegs];
  logic [DataW-1:0] regs_d [NumRegs];

  always_comb begin
    regs_d = regs_q;
    if (we_i) begin
      regs_d[waddr_i] = wdata_i;
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    if (raddr1_i == '0) begin
      rdata1_o = '0;
    end else if (we_i && (raddr1_i == waddr_i)) begin
      rdata1_o = wdata_i;
    end else begin
      rdata1_o = regs_q[raddr1_i];
    end
  end

  always_comb begin
    if (raddr2_i == '0) begin
      rdata2_o = '0;
    end else if (we_i && (raddr2_i == waddr_i)) begin
      rdata2_o = wdata_i;
    end else begin
      rdata2_o = regs_q[raddr2_i];
    end
  end

endmodule

// File: rtl/writeback_regfile.sv
// Writeback stage: commits results to the register file, serves decode reads with
// bypass, keeps cycle/instret counters and a registered commit trace record.
module writeback_regfile
  import writeback_regfile_pkg::*;
#(
  parameter int unsigned CNT_W = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  stage_status_t         stage_in,
  output stage_status_t         stage_out,
  input  logic [REG_ADDR_W-1:0] rs1_address,
  output logic [XLEN-1:0]       rs1_data,
  input  logic [REG_ADDR_W-1:0] rs2_address,
  output logic [XLEN-1:0]       rs2_data,
  output logic [REG_ADDR_W-1:0] fwd_address,
  output logic [XLEN-1:0]       fwd_data,
  output logic [CNT_W-1:0]      cycle_count,
  output logic [CNT_W-1:0]      instret_count
);

  logic          we;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  stage_status_t stage_out_q, stage_out_d;

  // Gating with rst_n keeps the bypass and forward outputs quiet while reset is held.
  always_comb begin
    we = rst_n & stage_in.valid & stage_in.data.valid & (stage_in.data.address != '0);
    fwd_address = we ? stage_in.data.address : '0;
    fwd_data    = we ? stage_in.data.data : '0;
  end

  always_comb begin
    cycle_d   = cycle_q + CNT_W'(1);
    instret_d = instret_q + CNT_W'(stage_in.valid);
    stage_out_d            = stage_in;
    stage_out_d.ready      = 1'b1;
    stage_out_d.data.valid = we;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_q     <= '0;
      instret_q   <= '0;
      stage_out_q <= '0;
    end else begin
      cycle_q     <= cycle_d;
      instret_q   <= instret_d;
      stage_out_q <= stage_out_d;
    end
  end

  assign cycle_count   = cycle_q;
  assign instret_count = instret_q;
  assign stage_out     = stage_out_q;

  writeback_regfile_register_file #(
    .DataW  (XLEN),
    .NumRegs(REG_COUNT),
    .AddrW  (REG_ADDR_W)
  ) u_register_file (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .we_i    (we),
    .waddr_i (stage_in.data.address),
    .wdata_i (stage_in.data.data),
    .raddr1_i(rs1_address),
    .rdata1_o(rs1_data),
    .raddr2_i(rs2_address),
    .rdata2_o(rs2_data)
  );

endmodule

// File: tb/tb_writeback_regfile.sv
// Bench for writeback_regfile: directed vector table, counter wrap on an 8-bit-counter
// build, then randomized traffic against an architectural reference model.
module tb_writeback_regfile;
  import writeback_regfile_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n;
  stage_status_t stage_in;
  logic [4:0]    rs1_address, rs2_address;

  stage_status_t stage_out, stage_out8;
  logic [31:0]   rs1_data, rs2_data, fwd_data, rs1_data8, rs2_data8, fwd_data8;
  logic [4:0]    fwd_address, fwd_address8;
  logic [63:0]   cycle_count, instret_count;
  logic [7:0]    cycle_count8, instret_count8;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  writeback_regfile #(.CNT_W(64)) dut (
    .clk(clk), .rst_n(rst_n), .stage_in(stage_in), .stage_out(stage_out),
    .rs1_address(rs1_address), .rs1_data(rs1_data),
    .rs2_address(rs2_address), .rs2_data(rs2_data),
    .fwd_address(fwd_address), .fwd_data(fwd_data),
    .cycle_count(cycle_count), .instret_count(instret_count)
  );

  writeback_regfile #(.CNT_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .stage_in(stage_in), .stage_out(stage_out8),
    .rs1_address(rs1_address), .rs1_data(rs1_data8),
    .rs2_address(rs2_address), .rs2_data(rs2_data8),
    .fwd_address(fwd_address8), .fwd_data(fwd_data8),
    .cycle_count(cycle_count8), .instret_count(instret_count8)
  );

  // Architectural reference state
  logic [31:0]   mdl_regs [32];
  logic [63:0]   mdl_cycle, mdl_instret;
  stage_status_t mdl_out;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic mdl_we();
    return rst_n && stage_in.valid && stage_in.data.valid && (stage_in.data.address != 0);
  endfunction

  function automatic logic [31:0] mdl_read(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (mdl_we() && a == stage_in.data.address) return stage_in.data.data;
    return mdl_regs[a];
  endfunction

  task automatic model_check();
    logic [31:0] e1, e2;
    e1 = mdl_read(rs1_address);
    e2 = mdl_read(rs2_address);
    chk("rs1_data", rs1_data, e1);
    chk("rs2_data", rs2_data, e2);
    chk("fwd_address", fwd_address, mdl_we() ? stage_in.data.address : 5'd0);
    chk("fwd_data", fwd_data, mdl_we() ? stage_in.data.data : 32'd0);
    chk("cycle_count", cycle_count, mdl_cycle);
    chk("instret_count", instret_count, mdl_instret);
    chk("stage_out", stage_out, mdl_out);
    chk("rs1_data_c8", rs1_data8, e1);
    chk("rs2_data_c8", rs2_data8, e2);
    chk("fwd_data_c8", {fwd_address8, fwd_data8}, {fwd_address, fwd_data});
    chk("stage_out_c8", stage_out8, mdl_out);
    chk("cycle_count_c8", cycle_count8, mdl_cycle[7:0]);
    chk("instret_count_c8", instret_count8, mdl_instret[7:0]);
  endtask

  task automatic model_update();
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mdl_regs[i] = 32'h0;
      mdl_cycle   = 64'd0;
      mdl_instret = 64'd0;
      mdl_out     = '0;
    end else begin
      if (mdl_we()) mdl_regs[stage_in.data.address] = stage_in.data.data;
      mdl_cycle   = mdl_cycle + 64'd1;
      mdl_instret = mdl_instret + (stage_in.valid ? 64'd1 : 64'd0);
      mdl_out            = stage_in;
      mdl_out.ready      = 1'b1;
      mdl_out.data.valid = mdl_we();
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic dv, input logic [4:0] rd,
                       input logic [31:0] d, input logic [4:0] a1, input logic [4:0] a2);
    rst_n                  = r;
    stage_in.valid         = v;
    stage_in.ready         = $urandom_range(0, 1);
    stage_in.pc            = v ? $urandom() : 32'h0;
    stage_in.instruction   = v ? $urandom() : 32'h0;
    stage_in.data.valid    = dv;
    stage_in.data.address  = rd;
    stage_in.data.data     = d;
    rs1_address            = a1;
    rs2_address            = a2;
  endtask

  task automatic step(input bit do_check);
    @(negedge clk);
    if (do_check) model_check();
    @(posedge clk);
    model_update();
    #1;
  endtask

  typedef struct {
    logic        r, v, dv;
    logic [4:0]  rd;
    logic [31:0] d;
    logic [4:0]  a1, a2;
    logic        c;
    logic [31:0] e_rs1, e_rs2;
    logic [4:0]  e_fwd;
    logic [63:0] e_cyc, e_ret;
    logic        e_ov, e_odv;
  } vec_t;

  vec_t vecs [12];

  initial begin
    vecs[0]  = '{0, 1, 1, 5, 32'hDEADBEEF, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{0, 1, 1, 5, 32'hDEADBEEF, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    vecs[2]  = '{1, 0, 0, 0, 32'h0, 5, 5, 1, 0, 0, 0, 0, 0, 0, 0};
    vecs[3]  = '{1, 1, 1, 5, 32'h12345678, 5, 0, 1, 32'h12345678, 0, 5, 1, 0, 0, 0};
    vecs[4]  = '{1, 0, 0, 0, 32'h0, 5, 5, 1, 32'h12345678, 32'h12345678, 0, 2, 1, 1, 1};
    vecs[5]  = '{1, 1, 1, 0, 32'hFFFFFFFF, 0, 0, 1, 0, 0, 0, 3, 1, 0, 0};
    vecs[6]  = '{1, 0, 0, 0, 32'h0, 0, 0, 1, 0, 0, 0, 4, 2, 1, 0};
    vecs[7]  = '{1, 1, 0, 7, 32'hAA, 7, 5, 1, 0, 32'h12345678, 0, 5, 2, 0, 0};
    vecs[8]  = '{1, 0, 0, 0, 32'h0, 7, 7, 1, 0, 0, 0, 6, 3, 1, 0};
    vecs[9]  = '{1, 1, 1, 3, 32'h1, 3, 3, 1, 1, 1, 3, 7, 3, 0, 0};
    vecs[10] = '{1, 1, 1, 3, 32'h2, 3, 3, 1, 2, 2, 3, 8, 4, 1, 1};
    vecs[11] = '{1, 0, 0, 0, 32'h0, 3, 3, 1, 2, 2, 0, 9, 5, 1, 1};

    for (int i = 0; i < 32; i++) mdl_regs[i] = 32'h0;
    mdl_cycle = 64'd0;
    mdl_instret = 64'd0;
    mdl_out = '0;

    // Directed vectors
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].r, vecs[i].v, vecs[i].dv, vecs[i].rd, vecs[i].d, vecs[i].a1, vecs[i].a2);
      @(negedge clk);
      if (vecs[i].c) begin
        chk($sformatf("vec%0d_rs1", i), rs1_data, vecs[i].e_rs1);
        chk($sformatf("vec%0d_rs2", i), rs2_data, vecs[i].e_rs2);
        chk($sformatf("vec%0d_fwd", i), fwd_address, vecs[i].e_fwd);
        chk($sformatf("vec%0d_cycle", i), cycle_count, vecs[i].e_cyc);
        chk($sformatf("vec%0d_instret", i), instret_count, vecs[i].e_ret);
        chk($sformatf("vec%0d_out_valid", i), stage_out.valid, vecs[i].e_ov);
        chk($sformatf("vec%0d_out_dvalid", i), stage_out.data.valid, vecs[i].e_odv);
        model_check();
      end
      @(posedge clk);
      model_update();
      #1;
    end

    // Counter wrap: 256 retires on the 8-bit build return instret to zero
    drive(0, 0, 0, 0, 0, 0, 0);
    step(1'b0);
    step(1'b1);
    for (int i = 0; i < 256; i++) begin
      drive(1, 1, 1, 5'($urandom_range(0, 31)), $urandom(),
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      step(1'b1);
    end
    drive(1, 0, 0, 0, 0, 9, 0);
    @(negedge clk);
    chk("wrap_instret_c8", instret_count8, 8'd0);
    chk("wrap_instret", instret_count, 64'd256);
    chk("wrap_cycle_c8", cycle_count8, 8'd0);
    @(posedge clk);
    model_update();
    #1;

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] rd;
      rd = 5'($urandom_range(0, 31));
      drive(($urandom_range(0, 99) != 0), $urandom_range(0, 1), $urandom_range(0, 1), rd,
            $urandom(),
            ($urandom_range(0, 1) != 0) ? rd : 5'($urandom_range(0, 31)),
            ($urandom_range(0, 1) != 0) ? rd : 5'($urandom_range(0, 31)));
      step(1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
